// File: rtl/fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the fetch sequencer and its in-flight branch queue:
// table sizes, reset PC, two-bit counter encodings, the queue entry layout
// and the saturating counter update helper.
// ---------------------------------------------------------------------------
package fetch_ctrl_pkg;

    localparam int BHT_DEPTH      = 16;
    localparam int BHT_IDX_W      = $clog2(BHT_DEPTH);
    localparam int INFLIGHT_DEPTH = 4;
    localparam int Q_PTR_W        = $clog2(INFLIGHT_DEPTH);
    localparam int Q_CNT_W        = $clog2(INFLIGHT_DEPTH + 1);

    localparam logic [31:0]        RESET_PC     = 32'h0000_0000;
    localparam logic [Q_CNT_W-1:0] Q_FULL_COUNT = Q_CNT_W'(INFLIGHT_DEPTH);

    // Two-bit branch history counter states.
    typedef enum logic [1:0] {
        SNT = 2'b00,   // strongly not taken
        WNT = 2'b01,   // weakly not taken
        WT  = 2'b10,   // weakly taken
        ST  = 2'b11    // strongly taken
    } bht_ctr_e;

    // One outstanding branch prediction awaiting resolution.
    typedef struct packed {
        logic [BHT_IDX_W-1:0] index;      // BHT slot to train on resolve
        logic                 predicted;  // direction used at fetch time
        logic [31:0]          alternate;  // PC to restart from if wrong
    } inflight_entry_t;

    localparam int ENTRY_W = $bits(inflight_entry_t);

    // Saturating two-bit counter step toward the resolved direction.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr,
                                              input logic       taken);
        logic [1:0] result;
        result = ctr;
        if (taken) begin
            if (ctr != ST) result = ctr + 2'd1;
        end else begin
            if (ctr != SNT) result = ctr - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_inflight_queue.sv
// ---------------------------------------------------------------------------
// branch_inflight_queue
// Small FIFO of predictions for branches that have been fetched but not yet
// resolved. Oldest entry is always visible on head.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset, empties the queue
//   push        write push_entry at the tail (ignored when full and no pop)
//   pop         drop the head entry (ignored when empty)
//   flush       empty the queue; wins over push and pop in the same cycle
//   push_entry  packed inflight_entry_t to enqueue
//   head        packed inflight_entry_t at the head (undefined when empty)
//   count       number of valid entries, 0..INFLIGHT_DEPTH
// ---------------------------------------------------------------------------
module branch_inflight_queue
    import fetch_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] push_entry,
    output logic [ENTRY_W-1:0] head,
    output logic [Q_CNT_W-1:0] count
);

    logic [ENTRY_W-1:0] mem [INFLIGHT_DEPTH];
    logic [Q_PTR_W-1:0] rd_ptr;
    logic [Q_PTR_W-1:0] wr_ptr;
    logic               do_push;
    logic               do_pop;

    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != Q_FULL_COUNT) || do_pop);

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + Q_PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + Q_PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + Q_CNT_W'(1);
                2'b01:   count <= count - Q_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates whether head is meaningful.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Instruction fetch address generator with a 16-entry two-bit branch history
// table and a queue of unresolved predictions. On a wrong prediction the PC
// restarts at the stored alternate path and a one-cycle flush pulse is sent
// to the downstream pipeline registers.
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   stall             hazard hold: PC frozen, no prediction recorded
//   is_branch         instruction at pc is a conditional branch
//   branch_target     taken target of that branch
//   jump_valid        instruction at pc is an unconditional jump
//   jump_target       target of that jump
//   resolve_valid     oldest in-flight branch resolved this cycle
//   resolve_taken     its actual direction
//   pc                registered fetch address
//   pred_bits         BHT counter for pc (combinational read)
//   mispredict        registered one-cycle flush pulse
//   queue_full_stall  fetch held because the in-flight queue is full
//   protocol_err      sticky: resolve arrived with nothing in flight
// ---------------------------------------------------------------------------
module fetch_sequencer
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        is_branch,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    output logic [31:0] pc,
    output logic [1:0]  pred_bits,
    output logic        mispredict,
    output logic        queue_full_stall,
    output logic        protocol_err
);

    logic [1:0]           bht [BHT_DEPTH];
    logic [BHT_IDX_W-1:0] fetch_idx;
    logic                 predicted_taken;
    logic [31:0]          pc_plus4;
    logic [31:0]          next_pc;

    logic [Q_CNT_W-1:0]   q_count;
    logic [ENTRY_W-1:0]   q_head_bits;
    inflight_entry_t      head_entry;
    inflight_entry_t      push_entry;
    logic                 resolve_ok;
    logic                 redirect;
    logic                 push_en;

    assign fetch_idx       = pc[BHT_IDX_W+1:2];
    assign pred_bits       = bht[fetch_idx];
    assign predicted_taken = pred_bits[1];
    assign pc_plus4        = pc + 32'd4;

    assign head_entry = inflight_entry_t'(q_head_bits);
    assign resolve_ok = resolve_valid && (q_count != '0);
    assign redirect   = resolve_ok && (resolve_taken != head_entry.predicted);

    // The head leaving this cycle makes room, so the stall clears at once.
    assign queue_full_stall = is_branch && (q_count == Q_FULL_COUNT) && !resolve_ok;

    assign push_en = is_branch && !stall && !queue_full_stall && !redirect;

    always_comb begin
        push_entry           = '0;
        push_entry.index     = fetch_idx;
        push_entry.predicted = predicted_taken;
        push_entry.alternate = predicted_taken ? pc_plus4 : branch_target;
    end

    always_comb begin
        next_pc = pc_plus4;
        if (redirect) begin
            next_pc = head_entry.alternate;
        end else if (stall || queue_full_stall) begin
            next_pc = pc;
        end else if (jump_valid) begin
            next_pc = jump_target;
        end else if (is_branch && predicted_taken) begin
            next_pc = branch_target;
        end
    end

    branch_inflight_queue u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_en),
        .pop        (resolve_ok),
        .flush      (redirect),
        .push_entry (push_entry),
        .head       (q_head_bits),
        .count      (q_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            mispredict   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            pc         <= next_pc;
            mispredict <= redirect;
            if (resolve_valid && (q_count == '0)) begin
                protocol_err <= 1'b1;
            end
        end
    end

    // Training is independent of stall; the fetch-side read above sees the
    // value from before this edge even when the same slot is being written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= WNT;
            end
        end else if (resolve_ok) begin
            bht[head_entry.index] <= sat_update(bht[head_entry.index], resolve_taken);
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        is_branch = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump_valid = 1'b0;
    logic [31:0] jump_target = '0;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    logic [31:0] pc;
    logic [1:0]  pred_bits;
    logic        mispredict;
    logic        queue_full_stall;
    logic        protocol_err;

    fetch_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .is_branch        (is_branch),
        .branch_target    (branch_target),
        .jump_valid       (jump_valid),
        .jump_target      (jump_target),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .pc               (pc),
        .pred_bits        (pred_bits),
        .mispredict       (mispredict),
        .queue_full_stall (queue_full_stall),
        .protocol_err     (protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [1:0]  pred;
        logic        mis;
        logic        qfs;
        logic        perr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "pc",               pc,                       e.pc);
                chk(e.name, "pred_bits",        {30'd0, pred_bits},       {30'd0, e.pred});
                chk(e.name, "mispredict",       {31'd0, mispredict},      {31'd0, e.mis});
                chk(e.name, "queue_full_stall", {31'd0, queue_full_stall}, {31'd0, e.qfs});
                chk(e.name, "protocol_err",     {31'd0, protocol_err},    {31'd0, e.perr});
            end
        end
    end

    // Driver: apply one cycle of inputs and queue the outputs expected for it.
    task automatic step(input string name,
                        input logic r, input logic s, input logic b,
                        input logic [31:0] bt, input logic j, input logic [31:0] jt,
                        input logic rv, input logic rt,
                        input logic [31:0] e_pc, input logic [1:0] e_pred,
                        input logic e_mis, input logic e_qfs, input logic e_perr);
        exp_t e;
        rst_n         = r;
        stall         = s;
        is_branch     = b;
        branch_target = bt;
        jump_valid    = j;
        jump_target   = jt;
        resolve_valid = rv;
        resolve_taken = rt;
        e.name = name;
        e.pc   = e_pc;
        e.pred = e_pred;
        e.mis  = e_mis;
        e.qfs  = e_qfs;
        e.perr = e_perr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        //    name         rst stl br  btgt          jv  jt            rv  rt   pc            pred   mis qfs perr
        step("reset_hold",  0, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h0000_0000, 2'b01, 0, 0, 0);
        step("seq_pc0",     1, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h0000_0000, 2'b01, 0, 0, 0);
        step("seq_pc4",     1, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h0000_0004, 2'b01, 0, 0, 0);
        step("seq_pc8",     1, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h0000_0008, 2'b01, 0, 0, 0);
        step("seq_pc12",    1, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h0000_000C, 2'b01, 0, 0, 0);
        step("br1_fetch",   1, 0, 1, 32'h40,       0, 32'h0,        0, 0,  32'h0000_0010, 2'b01, 0, 0, 0);
        step("br1_resolve", 1, 0, 0, 32'h0,        0, 32'h0,        1, 1,  32'h0000_0014, 2'b01, 0, 0, 0);
        step("br1_redir",   1, 0, 0, 32'h0,        1, 32'h10,       0, 0,  32'h0000_0040, 2'b01, 1, 0, 0);
        step("br2_fetch",   1, 0, 1, 32'h40,       0, 32'h0,        0, 0,  32'h0000_0010, 2'b10, 0, 0, 0);
        step("br2_resolve", 1, 0, 0, 32'h0,        0, 32'h0,        1, 0,  32'h0000_0040, 2'b01, 0, 0, 0);
        step("br2_redir",   1, 0, 0, 32'h0,        1, 32'h10,       0, 0,  32'h0000_0014, 2'b01, 1, 0, 0);
        step("br2_trained", 1, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h0000_0010, 2'b01, 0, 0, 0);
        step("fill_1",      1, 0, 1, 32'h100,      0, 32'h0,        0, 0,  32'h0000_0014, 2'b01, 0, 0, 0);
        step("fill_2",      1, 0, 1, 32'h100,      0, 32'h0,        0, 0,  32'h0000_0018, 2'b01, 0, 0, 0);
        step("fill_3",      1, 0, 1, 32'h100,      0, 32'h0,        0, 0,  32'h0000_001C, 2'b01, 0, 0, 0);
        step("fill_4",      1, 0, 1, 32'h100,      0, 32'h0,        0, 0,  32'h0000_0020, 2'b01, 0, 0, 0);
        step("full_a",      1, 0, 1, 32'h100,      0, 32'h0,        0, 0,  32'h0000_0024, 2'b01, 0, 1, 0);
        step("full_b",      1, 0, 1, 32'h100,      0, 32'h0,        0, 0,  32'h0000_0024, 2'b01, 0, 1, 0);
        step("full_pop",    1, 0, 1, 32'h100,      0, 32'h0,        1, 0,  32'h0000_0024, 2'b01, 0, 0, 0);
        step("full_mispr",  1, 0, 0, 32'h0,        0, 32'h0,        1, 1,  32'h0000_0028, 2'b01, 0, 0, 0);
        step("stall_jmp_a", 1, 1, 0, 32'h0,        1, 32'h80,       0, 0,  32'h0000_0100, 2'b01, 1, 0, 0);
        step("stall_jmp_b", 1, 1, 0, 32'h0,        1, 32'h80,       0, 0,  32'h0000_0100, 2'b01, 0, 0, 0);
        step("jmp_release", 1, 0, 0, 32'h0,        1, 32'h80,       0, 0,  32'h0000_0100, 2'b01, 0, 0, 0);
        step("empty_resolv",1, 0, 0, 32'h0,        0, 32'h0,        1, 1,  32'h0000_0080, 2'b01, 0, 0, 0);
        step("perr_sticky", 1, 0, 0, 32'h0,        1, 32'hFFFF_FFFC,0, 0,  32'h0000_0084, 2'b01, 0, 0, 1);
        step("pc_top",      1, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'hFFFF_FFFC, 2'b01, 0, 0, 1);
        step("pc_wrap",     1, 0, 0, 32'h0,        1, 32'h18,       0, 0,  32'h0000_0000, 2'b01, 0, 0, 1);
        step("ctr6_taken",  1, 0, 0, 32'h0,        1, 32'h14,       0, 0,  32'h0000_0018, 2'b10, 0, 0, 1);
        step("ctr5_sat",    1, 0, 1, 32'h200,      0, 32'h0,        0, 0,  32'h0000_0014, 2'b00, 0, 0, 1);
        step("inflight_2",  1, 0, 1, 32'h300,      0, 32'h0,        0, 0,  32'h0000_0018, 2'b10, 0, 0, 1);
        step("rst_mid_a",   0, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h0000_0000, 2'b01, 0, 0, 0);
        step("rst_mid_b",   0, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h0000_0000, 2'b01, 0, 0, 0);
        step("rst_release", 1, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h0000_0000, 2'b01, 0, 0, 0);
        step("post_rst_4",  1, 0, 0, 32'h0,        1, 32'h18,       0, 0,  32'h0000_0004, 2'b01, 0, 0, 0);
        step("post_rst_q",  1, 0, 0, 32'h0,        0, 32'h0,        1, 1,  32'h0000_0018, 2'b01, 0, 0, 0);
        step("post_rst_ok", 1, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h0000_001C, 2'b01, 0, 0, 1);
        step("same_push",   1, 0, 1, 32'h60,       0, 32'h0,        0, 0,  32'h0000_0020, 2'b01, 0, 0, 1);
        step("same_loop",   1, 0, 0, 32'h0,        1, 32'h20,       0, 0,  32'h0000_0024, 2'b01, 0, 0, 1);
        step("same_rd_wr",  1, 0, 1, 32'h60,       0, 32'h0,        1, 0,  32'h0000_0020, 2'b01, 0, 0, 1);
        step("same_pop2",   1, 0, 0, 32'h0,        0, 32'h0,        1, 0,  32'h0000_0024, 2'b01, 0, 0, 1);
        step("same_back",   1, 0, 0, 32'h0,        1, 32'h20,       0, 0,  32'h0000_0028, 2'b01, 0, 0, 1);
        step("same_final",  1, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h0000_0020, 2'b00, 0, 0, 1);

        repeat (4) begin
            if (exp_q.size() != 0) @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have rst_n, input, 1, reset (asynchronous, active-low).
REQ-003 SHALL have stall, input, 1, hazard-detector hold; PC frozen, no queue push.
REQ-004 SHALL have is_branch, input, 1, currently fetched instruction is beq.
REQ-005 SHALL have branch_target, input, 32, sign-extended offset<<2 + pc+4 of fetched branch.
REQ-006 SHALL have jump_valid / jump_target, input, 1/32, fetched instruction is j and its target.
REQ-007 SHALL have resolve_valid / resolve_taken, input, 1/1, EX/MEM resolution of oldest in-flight branch.
REQ-008 SHALL have pc, output, 32, registered fetch address.
REQ-009 SHALL have pred_bits, output, 2, BHT counter for current pc (combinational read).
REQ-010 SHALL have mispredict, output, 1, registered one-cycle flush pulse to IF/ID and ID/EX.
REQ-011 SHALL have queue_full_stall, output, 1, fetch held because in-flight queue full.
REQ-012 SHALL have protocol_err, output, 1, sticky: resolve_valid seen with empty queue.

Function
REQ-013 BHT SHALL hold 16 two-bit saturating counters indexed by pc[5:2]; predicted taken iff counter >= 2.
REQ-014 Next-PC priority SHALL be: redirect on mispredict > stall or queue_full_stall (hold) > jump_target > branch_target if is_branch and predicted taken > pc+4.
REQ-015 On is_branch with no stall, no full, no redirect, SHALL push {index, predicted, alternate} where alternate = pc+4 if predicted taken else branch_target.
REQ-016 In-flight queue SHALL be 4-deep FIFO; pointers wrap modulo 4; simultaneous push and pop SHALL keep count unchanged.
REQ-017 queue_full_stall SHALL be asserted combinationally when count==4 and is_branch; pop in the same cycle SHALL clear it.
REQ-018 On resolve_valid SHALL pop head and update its counter: taken increments saturating at 3, not-taken decrements saturating at 0; update occurs even if stall is high.
REQ-019 If resolve_taken != head.predicted, pc SHALL load head.alternate on that edge, queue SHALL empty, pending push SHALL be dropped, and mispredict SHALL be high exactly the following cycle.
REQ-020 Same-index push read and resolve write in one cycle SHALL read the pre-update value.
REQ-021 resolve_valid with empty queue SHALL be ignored except setting protocol_err.
REQ-022 pc arithmetic SHALL be 32-bit, wrap silently at 2^32.

Reset
REQ-023 rst_n low SHALL immediately set pc=0, all counters=2'b01, queue empty, mispredict=0, protocol_err=0.
REQ-024 Reset mid-flight SHALL discard all queued predictions without any update or flush pulse.

Structure
REQ-025 Shared package fetch_ctrl_pkg SHALL define BHT_DEPTH=16, INFLIGHT_DEPTH=4, RESET_PC=0, counter encodings SNT=00, WNT=01, WT=10, ST=11, and the queue entry type.
REQ-026 Queue SHALL be a sub-module branch_inflight_queue (push, pop, flush, count, head); BHT and next-PC mux stay in fetch_sequencer.

Verification
REQ-027 Reset, no branches, 5 cycles -> pc 0,4,8,12,16; pred_bits=01 everywhere.
REQ-028 Branch at pc=0x10, target 0x40, counter[4]=01, resolve taken -> fetch 0x14, then redirect pc=0x40, mispredict 1 cycle, counter[4]=10.
REQ-029 Same branch again predicted taken, resolve not-taken -> pc jumps 0x40, then redirected to 0x14, counter[4]=01.
REQ-030 Four unresolved branches then a fifth -> queue_full_stall=1, pc held; resolve_valid same cycle -> stall drops, push accepted.
REQ-031 stall=1 with jump_valid=1 target 0x80 -> pc held; stall release -> pc=0x80.
REQ-032 resolve_valid with empty queue -> protocol_err=1 and stays 1 until rst_n; rst_n pulse mid-flight -> pc=0, queue empty, no mispredict.
